muldiv_sched: RTL

- Multi-cycle scheduler for the HI/LO arithmetic resource. It is driven by the EX stage whenever the decoded ALU operation is MULT, MULTU, DIV or DIVU.
- It sequences a 32-iteration radix-2 restoring divider and a fixed-latency multiplier.
- It stalls EX while busy and delivers a registered {HI, LO} pair to the write-back of the HI/LO registers.
- Flushes from exceptions or ERET cancel in-flight work.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_sched_if.sv | 28 ++
 rtl/muldiv_sched_div_iter.sv | 45 ++++
 rtl/muldiv_sched.sv | 120 ++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the HI/LO mul/div scheduler.
// Op encodings, FSM states and the magnitude helper.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } md_state_e;

  function automatic logic [XLEN-1:0] md_abs(
    input logic [XLEN-1:0] v,
    input logic            neg
  );
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// muldiv_sched_if: EX-stage <-> mul/div scheduler bundle.
// master = EX side, slave = scheduler.
interface muldiv_sched_if;
  import muldiv_pkg::*;

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            ex_stall;
  logic            stall_req;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;

  modport master (
    output start, op, src_a, src_b, flush, ex_stall,
    input  stall_req, done, hi, lo, busy
  );

  modport slave (
    input  start, op, src_a, src_b, flush, ex_stall,
    output stall_req, done, hi, lo, busy
  );

endinterface

// File: rtl/muldiv_sched_div_iter.sv
// div_iter: radix-2 restoring divider datapath, one bit per step.
// quo/rem present the post-step values of the current state.
module div_iter
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  logic [XLEN-1:0] q_r;
  logic [XLEN-1:0] r_r;
  logic [XLEN-1:0] d_r;
  logic [XLEN:0]   sh;
  logic [XLEN:0]   diff;

  // rem < divisor holds, so the shifted value fits XLEN+1 bits
  always_comb begin
    sh   = {r_r, q_r[XLEN-1]};
    diff = sh - {1'b0, d_r};
    quo  = {q_r[XLEN-2:0], ~diff[XLEN]};
    rem  = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_r <= '0;
      r_r <= '0;
      d_r <= '0;
    end else if (load) begin
      q_r <= dividend;
      r_r <= '0;
      d_r <= divisor;
    end else if (step) begin
      q_r <= quo;
      r_r <= rem;
    end
  end

endmodule

// File: rtl/muldiv_sched.sv
// muldiv_sched: multi-cycle HI/LO mul/div scheduler with EX stall.
// MULDIV_DIV0_FAST_EN: divide by zero completes straight from IDLE.
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_ITERS  = 32
) (
  input logic           clk,
  input logic           resetn,
  muldiv_sched_if.slave md
);

  localparam int CW = 6;

  md_state_e       state, nstate;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] hi_r, lo_r;
  logic            sgn_op, in_neg_a, in_neg_b;
  logic            load, fast0, last;
  logic [XLEN-1:0] in_abs_a, in_abs_b;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo, rem, quo_s, rem_s;

  assign sgn_op   = ~md.op[0];
  assign in_neg_a = sgn_op & md.src_a[XLEN-1];
  assign in_neg_b = sgn_op & md.src_b[XLEN-1];
  assign in_abs_a = md_abs(md.src_a, in_neg_a);
  assign in_abs_b = md_abs(md.src_b, in_neg_b);
  assign load     = (state == IDLE) & md.start & ~md.flush;

`ifdef MULDIV_DIV0_FAST_EN
  assign fast0 = md.op[1] & ~|md.src_b;
`else
  assign fast0 = 1'b0;
`endif

  always_comb begin
    last = 1'b0;
    unique case (1'b1)
      state == MUL: last = cnt == CW'(MUL_CYCLES - 1);
      state == DIV: last = cnt == CW'(DIV_ITERS - 1);
      default:      last = 1'b0;
    endcase
  end

  // sign_a/sign_b are only ever set for signed ops
  assign prod   = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
  assign prod_s = (sign_a ^ sign_b) ? -prod : prod;
  assign quo_s  = (sign_a ^ sign_b) ? -quo : quo;
  assign rem_s  = sign_a ? -rem : rem;

  div_iter u_div (
    .clk      (clk),
    .resetn   (resetn),
    .load     (load),
    .step     (state == DIV),
    .dividend (in_abs_a),
    .divisor  (in_abs_b),
    .quo      (quo),
    .rem      (rem)
  );

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (load) nstate = fast0 ? DONE : (md.op[1] ? DIV : MUL);
      MUL:  if (last) nstate = DONE;
      DIV:  if (last) nstate = DONE;
      DONE: if (!md.ex_stall) nstate = IDLE;
      default: nstate = IDLE;
    endcase
    if (md.flush) nstate = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      state <= nstate;
      cnt   <= (nstate != state) ? '0 : cnt + CW'(1);
      if (load) begin
        mag_a  <= in_abs_a;
        mag_b  <= in_abs_b;
        sign_a <= in_neg_a;
        sign_b <= in_neg_b;
      end
      if (!md.flush) begin
        if (state == MUL && last) begin
          hi_r <= prod_s[2*XLEN-1:XLEN];
          lo_r <= prod_s[XLEN-1:0];
        end
        if (state == DIV && last) begin
          hi_r <= rem_s;
          lo_r <= quo_s;
        end
        if (load && fast0) begin
          hi_r <= md.src_a;
          lo_r <= '1;
        end
      end
    end
  end

  assign md.done      = (state == DONE) & ~md.flush;
  assign md.stall_req = md.start & (state != DONE) & ~md.flush;
  assign md.busy      = state != IDLE;
  assign md.hi        = hi_r;
  assign md.lo        = lo_r;

endmodule
